// File: rtl/frame_downscaler.sv
// frame_downscaler
//   Decimates a raster pixel stream by H_DEC horizontally and V_DEC vertically
//   and writes each output pixel to a frame RAM through a 1-cycle write port.
//   Per-frame mode (latched on v_sync): subsample (first pixel of each group)
//   or horizontal box average (truncated mean of each group).
// Ports
//   clk, rst          clock, synchronous active-high reset
//   din, din_valid    input pixel and its qualifier
//   h_sync, v_sync    1-cycle line / frame start pulses
//   avg_en            0=subsample, 1=average; sampled on v_sync only
//   wr_en/addr/data   registered RAM write port
//   frame_done        pulses together with the last write of a frame
//   busy              high while waiting for or processing a line
module frame_downscaler #(
  parameter int PIX_W    = 8,
  parameter int H_PIXELS = 768,
  parameter int V_PIXELS = 512,
  parameter int H_DEC    = 2,
  parameter int V_DEC    = 2,
  parameter int ADDR_W   = $clog2((H_PIXELS/H_DEC)*(V_PIXELS/V_DEC))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  din,
  input  logic              din_valid,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              avg_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int HL    = $clog2(H_DEC);
  localparam int PH_W  = (HL > 0) ? HL : 1;
  localparam int ACC_W = PIX_W + HL;
  localparam int V_OUT = V_PIXELS / V_DEC;
  localparam int PC_W  = $clog2(H_PIXELS + 1);
  localparam int KC_W  = $clog2(V_OUT + 1);
  localparam int LP_W  = ($clog2(V_DEC) > 0) ? $clog2(V_DEC) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [LP_W-1:0]   line_ph;    // input line index mod V_DEC
  logic [KC_W-1:0]   kept_cnt;   // kept lines started this frame
  logic [PC_W-1:0]   pix_cnt;
  logic [PH_W-1:0]   phase;
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] next_addr;
  logic              mode;

  logic              take_line, keep, accept, do_wr, last_grp, grp_end;
  logic [ACC_W-1:0]  acc_sum;
  logic [PIX_W-1:0]  wr_val;

  always_comb begin
    state_d   = state_q;
    take_line = 1'b0;
    accept    = 1'b0;
    keep      = (line_ph == '0);
    if (v_sync) begin
      state_d = WAIT_LINE;
    end else begin
      case (state_q)
        WAIT_LINE: if (h_sync) begin
          take_line = 1'b1;
          state_d   = keep ? ACTIVE : WAIT_LINE;
        end
        ACTIVE: if (h_sync) begin
          // abandons the current line; a partial group is dropped
          take_line = 1'b1;
          state_d   = keep ? ACTIVE : WAIT_LINE;
        end else if (din_valid) begin
          accept = 1'b1;
          if (pix_cnt == PC_W'(H_PIXELS - 1))
            state_d = (kept_cnt == KC_W'(V_OUT)) ? DONE : WAIT_LINE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grp_end  = (phase == PH_W'(H_DEC - 1));
    acc_sum  = acc + ACC_W'(din);
    do_wr    = accept && (mode ? grp_end : (phase == '0));
    wr_val   = mode ? PIX_W'(acc_sum >> HL) : din;
    // any write from the last group of the final kept line is the frame's last
    last_grp = (kept_cnt == KC_W'(V_OUT)) && (pix_cnt >= PC_W'(H_PIXELS - H_DEC));
    busy     = (state_q == WAIT_LINE) || (state_q == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_ph    <= '0;
      kept_cnt   <= '0;
      pix_cnt    <= '0;
      phase      <= '0;
      acc        <= '0;
      next_addr  <= '0;
      mode       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en      <= do_wr;
      frame_done <= do_wr && last_grp;
      if (do_wr) begin
        wr_addr   <= next_addr;
        wr_data   <= wr_val;
        next_addr <= next_addr + 1'b1;
      end
      if (v_sync) begin
        line_ph   <= '0;
        kept_cnt  <= '0;
        pix_cnt   <= '0;
        phase     <= '0;
        acc       <= '0;
        next_addr <= '0;
        mode      <= avg_en;
      end else if (take_line) begin
        line_ph  <= (line_ph == LP_W'(V_DEC - 1)) ? '0 : line_ph + 1'b1;
        if (keep) kept_cnt <= kept_cnt + 1'b1;
        pix_cnt  <= '0;
        phase    <= '0;
        acc      <= '0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + 1'b1;
        phase   <= grp_end ? '0 : phase + 1'b1;
        acc     <= grp_end ? '0 : acc_sum;
      end
    end
  end

endmodule
